// File: rtl/thread_stall_tracker_pkg.sv
// Shared types for the thread stall tracker.
// Thread ids, fill tags and per-thread stall states.
package thread_stall_tracker_pkg;

  localparam int n_threads     = 8;
  localparam int THREAD_W      = $clog2(n_threads);
  localparam int FILL_ID_W_DEF = 3;
  localparam int NWAIT_W       = $clog2(n_threads + 1);

  typedef logic [THREAD_W-1:0]      threadid_t;
  typedef logic [FILL_ID_W_DEF-1:0] fillid_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_FILL,
    ST_WAKE
  } stall_state_t;

endpackage

// File: rtl/thread_stall_tracker_if.sv
// Miss / fill / exception bus into the tracker.
// master: miss_*, fill_*, exc_* out; stalled, n_waiting, proto_err in.
interface thread_stall_tracker_if
  import thread_stall_tracker_pkg::*;
#(
  parameter int FILL_ID_W = FILL_ID_W_DEF
) ();

  logic                 miss_en;
  threadid_t            miss_thread;
  logic [FILL_ID_W-1:0] miss_id;
  logic                 fill_en;
  logic [FILL_ID_W-1:0] fill_id;
  logic                 exc_en;
  threadid_t            exc_thread;
  logic                 stalled [n_threads-1:0];
  logic [NWAIT_W-1:0]   n_waiting;
  logic                 proto_err;

  modport master (
    output miss_en, miss_thread, miss_id,
    output fill_en, fill_id,
    output exc_en, exc_thread,
    input  stalled, n_waiting, proto_err
  );

  modport slave (
    input  miss_en, miss_thread, miss_id,
    input  fill_en, fill_id,
    input  exc_en, exc_thread,
    output stalled, n_waiting, proto_err
  );

endinterface

// File: rtl/thread_stall_tracker_slot.sv
// One thread's stall FSM: RUN / WAIT_FILL / WAKE, fill tag, wake counter.
// Ports: clk, rst, sel_miss, sel_exc, fill_en, fill_id, miss_id -> state, bad_miss.
module thread_stall_slot
  import thread_stall_tracker_pkg::*;
#(
  parameter int FILL_ID_W  = FILL_ID_W_DEF,
  parameter int WAKE_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_miss,
  input  logic                 sel_exc,
  input  logic                 fill_en,
  input  logic [FILL_ID_W-1:0] fill_id,
  input  logic [FILL_ID_W-1:0] miss_id,
  output stall_state_t         state,
  output logic                 bad_miss
);

  localparam int CNT_W =
    (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAKE_DELAY);
  // Zero delay skips the WAKE phase entirely.
  localparam stall_state_t ST_FILLED =
    (WAKE_DELAY > 0) ? ST_WAKE : ST_RUN;

  stall_state_t         r_state;
  stall_state_t         w_state_nxt;
  logic [FILL_ID_W-1:0] r_tag;
  logic [FILL_ID_W-1:0] w_tag_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_fill_hit;

  assign w_fill_hit = fill_en && (fill_id == r_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_tag   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tag_nxt   = r_tag;
    w_cnt_nxt   = r_cnt;
    bad_miss    = 1'b0;
    if (sel_exc) begin
      // Redirect wins over any miss or fill on this thread.
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (sel_miss) begin
            w_state_nxt = ST_WAIT_FILL;
            w_tag_nxt   = miss_id;
          end
        end
        ST_WAIT_FILL: begin
          bad_miss = sel_miss;
          if (w_fill_hit) begin
            w_state_nxt = ST_FILLED;
            w_cnt_nxt   = CNT_INIT;
          end
        end
        ST_WAKE: begin
          bad_miss = sel_miss;
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: rtl/thread_stall_tracker.sv
// Per-thread stall tracker feeding the scheduler's stalled mask.
// Ports: clk, rst, bus (slave): miss/fill/exc in; stalled, n_waiting, proto_err out.
module thread_stall_tracker
  import thread_stall_tracker_pkg::*;
#(
  parameter int FILL_ID_W  = FILL_ID_W_DEF,
  parameter int WAKE_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  thread_stall_tracker_if.slave bus
);

  stall_state_t         w_state [n_threads];
  logic [n_threads-1:0] w_sel_miss;
  logic [n_threads-1:0] w_sel_exc;
  logic [n_threads-1:0] w_bad_miss;
  logic [NWAIT_W-1:0]   w_n_waiting;
  logic                 r_proto_err;

  always_comb begin
    w_sel_miss = '0;
    w_sel_exc  = '0;
    w_sel_miss[bus.miss_thread] = bus.miss_en;
    w_sel_exc[bus.exc_thread]   = bus.exc_en;
  end

  for (genvar g = 0; g < n_threads; g++) begin : g_slot
    thread_stall_slot #(
      .FILL_ID_W  (FILL_ID_W),
      .WAKE_DELAY (WAKE_DELAY)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .sel_miss (w_sel_miss[g]),
      .sel_exc  (w_sel_exc[g]),
      .fill_en  (bus.fill_en),
      .fill_id  (bus.fill_id),
      .miss_id  (bus.miss_id),
      .state    (w_state[g]),
      .bad_miss (w_bad_miss[g])
    );
    assign bus.stalled[g] = (w_state[g] != ST_RUN);
  end

  always_comb begin
    w_n_waiting = '0;
    for (int i = 0; i < n_threads; i++) begin
      if (w_state[i] == ST_WAIT_FILL)
        w_n_waiting = w_n_waiting + NWAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_proto_err <= 1'b0;
    else if (|w_bad_miss)
      r_proto_err <= 1'b1;
  end

  assign bus.n_waiting = w_n_waiting;
  assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_thread_stall_tracker.sv
// Bench for thread_stall_tracker: WAKE_DELAY=2 and =0 side by side.
// Directed scenarios plus random traffic against a timestamp model.
module tb_thread_stall_tracker;
  import thread_stall_tracker_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  thread_stall_tracker_if bus ();
  thread_stall_tracker_if bus_z ();

  assign bus_z.miss_en     = bus.miss_en;
  assign bus_z.miss_thread = bus.miss_thread;
  assign bus_z.miss_id     = bus.miss_id;
  assign bus_z.fill_en     = bus.fill_en;
  assign bus_z.fill_id     = bus.fill_id;
  assign bus_z.exc_en      = bus.exc_en;
  assign bus_z.exc_thread  = bus.exc_thread;

  thread_stall_tracker #(.FILL_ID_W(3), .WAKE_DELAY(2)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  thread_stall_tracker #(.FILL_ID_W(3), .WAKE_DELAY(0)) u_dut_z (
    .clk (clk), .rst (rst), .bus (bus_z)
  );

  logic [7:0] s2, s0;
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s2[i] = bus.stalled[i];
      s0[i] = bus_z.stalled[i];
    end
  end

  int total = 0;
  int bad = 0;

  // Model: index 0 = delay 2, index 1 = delay 0.
  // blk = tag a thread waits on (-1 none); rel = edge count
  // until which it stays blocked after its fill.
  int m_blk [2][8];
  int m_rel [2][8];
  bit m_perr [2];
  int cyc = 0;

  function automatic logic [7:0] exp_vec(int d);
    logic [7:0] v;
    for (int t = 0; t < 8; t++)
      v[t] = (m_blk[d][t] >= 0) || (cyc < m_rel[d][t]);
    return v;
  endfunction

  function automatic logic [3:0] exp_nw(int d);
    int n = 0;
    for (int t = 0; t < 8; t++)
      if (m_blk[d][t] >= 0) n++;
    return 4'(n);
  endfunction

  task automatic model_edge();
    int wd;
    int mt;
    bit pre [8];
    bit exc_here;
    for (int d = 0; d < 2; d++) begin
      wd = (d == 0) ? 2 : 0;
      if (rst) begin
        for (int t = 0; t < 8; t++) begin
          m_blk[d][t] = -1;
          m_rel[d][t] = 0;
        end
        m_perr[d] = 1'b0;
      end else begin
        for (int t = 0; t < 8; t++)
          pre[t] = (m_blk[d][t] >= 0) || (cyc < m_rel[d][t]);
        for (int t = 0; t < 8; t++) begin
          if (bus.fill_en && m_blk[d][t] == int'(bus.fill_id)) begin
            m_blk[d][t] = -1;
            m_rel[d][t] = cyc + 1 + wd;
          end
        end
        if (bus.miss_en) begin
          mt = int'(bus.miss_thread);
          exc_here = bus.exc_en && (bus.exc_thread == bus.miss_thread);
          if (!exc_here) begin
            if (pre[mt]) m_perr[d] = 1'b1;
            else m_blk[d][mt] = int'(bus.miss_id);
          end
        end
        if (bus.exc_en) begin
          m_blk[d][int'(bus.exc_thread)] = -1;
          m_rel[d][int'(bus.exc_thread)] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input bit r, input bit me, input int mt,
                      input int mi, input bit fe, input int fi,
                      input bit ee, input int et);
    @(negedge clk);
    rst             = r;
    bus.miss_en     = me;
    bus.miss_thread = threadid_t'(mt);
    bus.miss_id     = 3'(mi);
    bus.fill_en     = fe;
    bus.fill_id     = 3'(fi);
    bus.exc_en      = ee;
    bus.exc_thread  = threadid_t'(et);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (s2 !== 8'h00) begin bad++; $display("FAIL reset_stalled got=%h exp=00", s2); end
    total++; if (bus.n_waiting !== 4'd0) begin bad++; $display("FAIL reset_nwait got=%0d exp=0", bus.n_waiting); end
    total++; if (bus.proto_err !== 1'b0 || bus_z.proto_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b/%b exp=0", bus.proto_err, bus_z.proto_err); end
  endtask

  task automatic test_wake();
    step(0, 1, 3, 5, 0, 0, 0, 0);
    total++; if (s2 !== 8'h08 || s0 !== 8'h08) begin bad++; $display("FAIL wake_miss got=%h/%h exp=08", s2, s0); end
    total++; if (bus.n_waiting !== 4'd1) begin bad++; $display("FAIL wake_nwait got=%0d exp=1", bus.n_waiting); end
    repeat (4) idle();
    total++; if (s2 !== 8'h08) begin bad++; $display("FAIL wake_hold got=%h exp=08", s2); end
    step(0, 0, 0, 0, 1, 5, 0, 0);
    total++; if (s2 !== 8'h08) begin bad++; $display("FAIL wake_d1 got=%h exp=08", s2); end
    total++; if (s0 !== 8'h00) begin bad++; $display("FAIL wake_zero got=%h exp=00", s0); end
    total++; if (bus.n_waiting !== 4'd0) begin bad++; $display("FAIL wake_nwait0 got=%0d exp=0", bus.n_waiting); end
    idle();
    total++; if (s2 !== 8'h08) begin bad++; $display("FAIL wake_d2 got=%h exp=08", s2); end
    idle();
    total++; if (s2 !== 8'h00) begin bad++; $display("FAIL wake_run got=%h exp=00", s2); end
  endtask

  task automatic test_shared_fill();
    step(0, 1, 1, 2, 0, 0, 0, 0);
    step(0, 1, 6, 2, 0, 0, 0, 0);
    total++; if (bus.n_waiting !== 4'd2 || s2 !== 8'h42) begin bad++; $display("FAIL shared_wait got=%0d,%h exp=2,42", bus.n_waiting, s2); end
    step(0, 0, 0, 0, 1, 2, 0, 0);
    total++; if (bus.n_waiting !== 4'd0 || s0 !== 8'h00) begin bad++; $display("FAIL shared_fill got=%0d,%h exp=0,00", bus.n_waiting, s0); end
    idle(); idle();
    total++; if (s2 !== 8'h00) begin bad++; $display("FAIL shared_run got=%h exp=00", s2); end
  endtask

  task automatic test_exception();
    step(0, 1, 4, 1, 0, 0, 0, 0);
    step(0, 1, 5, 6, 0, 0, 0, 0);
    total++; if (s2 !== 8'h30) begin bad++; $display("FAIL exc_wait got=%h exp=30", s2); end
    // exc t4 + fill id1 + new miss on t0, all at once
    step(0, 1, 0, 1, 1, 1, 1, 4);
    total++; if (s2 !== 8'h21 || s0 !== 8'h21) begin bad++; $display("FAIL exc_beats got=%h/%h exp=21", s2, s0); end
    step(0, 0, 0, 0, 0, 0, 1, 5);
    total++; if (s2 !== 8'h01 || bus.n_waiting !== 4'd1) begin bad++; $display("FAIL exc_t5 got=%h,%0d exp=01,1", s2, bus.n_waiting); end
    step(0, 0, 0, 0, 1, 6, 0, 0);
    total++; if (s2 !== 8'h01) begin bad++; $display("FAIL exc_oldtag got=%h exp=01", s2); end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    total++; if (s2 !== 8'h00 || bus.proto_err !== 1'b0) begin bad++; $display("FAIL exc_clear got=%h,%b exp=00,0", s2, bus.proto_err); end
  endtask

  task automatic test_proto_err();
    step(0, 1, 2, 3, 0, 0, 0, 0);
    step(0, 1, 2, 7, 0, 0, 0, 0);
    total++; if (bus.proto_err !== 1'b1 || bus_z.proto_err !== 1'b1) begin bad++; $display("FAIL perr_set got=%b/%b exp=1", bus.proto_err, bus_z.proto_err); end
    step(0, 0, 0, 0, 1, 7, 0, 0);
    total++; if (s2 !== 8'h04 || bus.n_waiting !== 4'd1) begin bad++; $display("FAIL perr_tag got=%h,%0d exp=04,1", s2, bus.n_waiting); end
    // Illegal miss alongside the real fill: fill still applies.
    step(0, 1, 2, 5, 1, 3, 0, 0);
    total++; if (s0 !== 8'h00 || bus.n_waiting !== 4'd0) begin bad++; $display("FAIL perr_fill got=%h,%0d exp=00,0", s0, bus.n_waiting); end
    idle(); idle();
    total++; if (s2 !== 8'h00 || bus.proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky got=%h,%b exp=00,1", s2, bus.proto_err); end
  endtask

  task automatic test_all_threads();
    for (int t = 0; t < 8; t++) step(0, 1, t, t, 0, 0, 0, 0);
    total++; if (s2 !== 8'hff || bus.n_waiting !== 4'd8) begin bad++; $display("FAIL all_wait got=%h,%0d exp=ff,8", s2, bus.n_waiting); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (s2 !== 8'h00 || bus.n_waiting !== 4'd0 || bus.proto_err !== 1'b0) begin bad++; $display("FAIL all_rst got=%h,%0d,%b exp=00,0,0", s2, bus.n_waiting, bus.proto_err); end
    step(0, 0, 0, 0, 1, 3, 0, 0);
    total++; if (s2 !== 8'h00) begin bad++; $display("FAIL all_droptag got=%h exp=00", s2); end
  endtask

  task automatic test_unused_fill();
    step(0, 1, 0, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 6, 0, 0);
    total++; if (s0 !== 8'h01 || bus_z.proto_err !== 1'b0) begin bad++; $display("FAIL unused_fill got=%h,%b exp=01,0", s0, bus_z.proto_err); end
    step(0, 0, 0, 0, 1, 2, 0, 0);
    total++; if (s0 !== 8'h00) begin bad++; $display("FAIL zero_wake got=%h exp=00", s0); end
    idle(); idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 4), $urandom_range(0, 7),
           $urandom_range(0, 7),
           ($urandom_range(0, 9) < 4), $urandom_range(0, 7),
           ($urandom_range(0, 19) == 0), $urandom_range(0, 7));
      total++; if (s2 !== exp_vec(0)) begin bad++; $display("FAIL rnd_stall2 n=%0d got=%h exp=%h", n, s2, exp_vec(0)); end
      total++; if (s0 !== exp_vec(1)) begin bad++; $display("FAIL rnd_stall0 n=%0d got=%h exp=%h", n, s0, exp_vec(1)); end
      total++; if (bus.n_waiting !== exp_nw(0)) begin bad++; $display("FAIL rnd_nw2 n=%0d got=%0d exp=%0d", n, bus.n_waiting, exp_nw(0)); end
      total++; if (bus_z.n_waiting !== exp_nw(1)) begin bad++; $display("FAIL rnd_nw0 n=%0d got=%0d exp=%0d", n, bus_z.n_waiting, exp_nw(1)); end
      total++; if (bus.proto_err !== m_perr[0]) begin bad++; $display("FAIL rnd_perr2 n=%0d got=%b exp=%b", n, bus.proto_err, m_perr[0]); end
      total++; if (bus_z.proto_err !== m_perr[1]) begin bad++; $display("FAIL rnd_perr0 n=%0d got=%b exp=%b", n, bus_z.proto_err, m_perr[1]); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 8; t++) begin
        m_blk[d][t] = -1;
        m_rel[d][t] = 0;
      end
      m_perr[d] = 1'b0;
    end
    rst = 1'b1;
    bus.miss_en = 1'b0; bus.miss_thread = '0; bus.miss_id = '0;
    bus.fill_en = 1'b0; bus.fill_id = '0;
    bus.exc_en = 1'b0; bus.exc_thread = '0;
    test_reset();
    test_wake();
    test_shared_fill();
    test_exception();
    test_proto_err();
    test_all_threads();
    test_unused_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
